// File: rtl/psum_pkg.sv
// Shared constants for the psum output-FIFO reader blocks.
//   COL / BW_PSUM : array geometry (columns per core, bits per partial sum)
//   LANES         : psum words per FIFO row (two cores side by side)
//   FIFO_DEPTH    : entries per output FIFO
//   OCC_W         : occupancy counter width, wide enough to hold FIFO_DEPTH
//   state_t       : drain FSM state encoding
package psum_pkg;

    localparam int unsigned COL        = 8;
    localparam int unsigned BW_PSUM    = 20;
    localparam int unsigned LANES      = 2 * COL;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned OCC_W      = 5;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StWait  = 2'd2;
    localparam state_t StSend  = 2'd3;

endpackage

// File: rtl/psum_occ_cnt.sv
// Saturating up/down occupancy counter for a FIFO reader, with sticky overflow.
//   clk    : clock, posedge
//   reset  : synchronous, active-high
//   inc    : one entry pushed this cycle
//   dec    : one entry popped this cycle
//   cnt    : entries held (0..Depth)
//   ovf    : set by a push at full without a pop; cleared only by reset
module psum_occ_cnt
    import psum_pkg::*;
#(
    parameter int unsigned Depth = FIFO_DEPTH,
    parameter int unsigned Width = OCC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [Width-1:0] cnt,
    output logic             ovf
);

    localparam logic [Width-1:0] Max = Width'(Depth);

    logic [Width-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // Push and pop in the same cycle cancel, even at full or empty.
        if (inc && !dec) begin
            if (cnt_q == Max) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/psum_drain.sv
// Reader end of the fullchip output FIFO pair. Counts rows pushed by watching the
// FIFO write strobe, issues one read per row and serialises each row LSB-first
// into single psum words on a valid/ready stream.
//   clk      : clock, posedge
//   reset    : synchronous, active-high; a row in flight is discarded
//   fifo_wr  : copy of the FIFO write strobe, one row per high cycle
//   fifo_out : {core0 row, core1 row} from the FIFOs
//   fifo_rd  : registered FIFO read strobe
//   o_data   : current psum word
//   o_valid  : o_data valid
//   o_last   : final word of the current row
//   o_ready  : downstream accepts on o_valid && o_ready
//   occ      : rows in the FIFO not yet read
//   ovf      : sticky overflow
module psum_drain
    import psum_pkg::*;
#(
    parameter int unsigned col        = COL,
    parameter int unsigned bw_psum    = BW_PSUM,
    parameter int unsigned fifo_depth = FIFO_DEPTH,
    parameter int unsigned rd_lat     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_wr,
    input  logic [2*col*bw_psum-1:0] fifo_out,
    output logic                     fifo_rd,
    output logic [bw_psum-1:0]       o_data,
    output logic                     o_valid,
    output logic                     o_last,
    input  logic                     o_ready,
    output logic [OCC_W-1:0]         occ,
    output logic                     ovf
);

    localparam int unsigned Lanes = 2 * col;
    localparam int unsigned LaneW = $clog2(Lanes);
    localparam int unsigned RowW  = 2 * col * bw_psum;
    localparam int unsigned WaitW = 2;

    localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);
    localparam logic [WaitW-1:0] WaitLoad = WaitW'(rd_lat);

    state_t           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [LaneW-1:0] lane_q, lane_d;
    logic [RowW-1:0]  shreg_q, shreg_d;
    logic             rd_q;
    logic             hs;

    psum_occ_cnt #(
        .Depth (fifo_depth),
        .Width (OCC_W)
    ) u_occ_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fifo_wr),
        .dec   (rd_q),
        .cnt   (occ),
        .ovf   (ovf)
    );

    assign hs = o_valid && o_ready;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        lane_d  = lane_q;
        shreg_d = shreg_q;
        unique case (state_q)
            StIdle: begin
                if (occ != '0) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wait_d  = WaitLoad;
                state_d = StWait;
            end
            StWait: begin
                // fifo_out becomes valid rd_lat edges after the read; capture on the last one.
                if (wait_q == WaitW'(1)) begin
                    shreg_d = fifo_out;
                    lane_d  = '0;
                    state_d = StSend;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            StSend: begin
                if (hs) begin
                    shreg_d = shreg_q >> bw_psum;
                    lane_d  = lane_q + 1'b1;
                    if (lane_q == LastLane) begin
                        // Go straight to the next read when rows are waiting.
                        state_d = (occ != '0) ? StIssue : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            wait_q  <= '0;
            lane_q  <= '0;
            shreg_q <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
            // Registered strobe that is high exactly while the FSM sits in StIssue.
            rd_q    <= (state_d == StIssue);
        end
    end

    assign fifo_rd = rd_q;
    assign o_valid = (state_q == StSend);
    assign o_data  = shreg_q[bw_psum-1:0];
    assign o_last  = o_valid && (lane_q == LastLane);

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;
    import psum_pkg::*;

    localparam int unsigned RowW = 2 * COL * BW_PSUM;

    typedef struct packed {
        logic [BW_PSUM-1:0] data;
        logic               last;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               fifo_wr;
    logic [RowW-1:0]    fifo_out;
    logic               fifo_rd;
    logic [BW_PSUM-1:0] o_data;
    logic               o_valid;
    logic               o_last;
    logic               o_ready;
    logic [OCC_W-1:0]   occ;
    logic               ovf;

    logic [RowW-1:0]    wr_row;
    logic [RowW-1:0]    fq[$];
    exp_t               exp_q[$];

    int total = 0;
    int bad   = 0;

    // Monitor state, only touched from the stimulus process.
    int  cyc         = 0;
    int  rd_cnt      = 0;
    int  hs_cnt      = 0;
    int  last_cnt    = 0;
    int  vld_cnt     = 0;
    int  last_rd_cyc = -100;
    bit  prev_valid  = 1'b0;
    bit  held        = 1'b0;
    logic [BW_PSUM-1:0] held_data;
    logic               held_last;
    int  rd_cycs[$];
    int  last_cycs[$];

    psum_drain dut (
        .clk      (clk),
        .reset    (reset),
        .fifo_wr  (fifo_wr),
        .fifo_out (fifo_out),
        .fifo_rd  (fifo_rd),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .o_ready  (o_ready),
        .occ      (occ),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Output FIFO model with a one-cycle read latency; it is reset along with the DUT.
    always @(posedge clk) begin
        if (reset) begin
            fq.delete();
            fifo_out <= '0;
        end else begin
            if (fifo_rd) begin
                if (fq.size() > 0) fifo_out <= fq.pop_front();
                else               fifo_out <= 'x;
            end
            if (fifo_wr && fq.size() < FIFO_DEPTH) fq.push_back(wr_row);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge (scoreboard, hold, latency), then step to posedge+1.
    task automatic cycle();
        exp_t e;
        logic [31:0] have;
        @(negedge clk);
        if (held) begin
            check("hold_valid", o_valid, 1);
            check("hold_data", o_data, held_data);
            check("hold_last", o_last, held_last);
            held = 1'b0;
        end
        if (fifo_rd) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            rd_cycs.push_back(cyc);
        end
        if (o_valid && !prev_valid) check("valid_latency", cyc - last_rd_cyc, 2);
        prev_valid = o_valid;
        if (o_valid) vld_cnt++;
        if (o_valid && o_ready) begin
            hs_cnt++;
            have = (exp_q.size() > 0) ? 32'd1 : 32'd0;
            check("sb_nonempty", have, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("word_data", o_data, e.data);
                check("word_last", o_last, e.last);
            end
            if (o_last) begin
                last_cnt++;
                last_cycs.push_back(cyc);
            end
        end else if (o_valid && !o_ready && !reset) begin
            held      = 1'b1;
            held_data = o_data;
            held_last = o_last;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One-cycle write of a row whose word k is base+k+1; expectations queued now.
    task automatic wr_pulse(input int base);
        logic [RowW-1:0] row;
        exp_t e;
        row = '0;
        for (int k = 0; k < LANES; k++) begin
            row[k*BW_PSUM +: BW_PSUM] = BW_PSUM'(base + k + 1);
            e.data = BW_PSUM'(base + k + 1);
            e.last = (k == LANES - 1);
            exp_q.push_back(e);
        end
        wr_row  = row;
        fifo_wr = 1'b1;
        cycle();
        fifo_wr = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && hs_cnt < target; i++) cycle();
        check(tag, hs_cnt, target);
    endtask

    initial begin
        int rd0, h0, l0, v0;
        reset   = 1'b1;
        fifo_wr = 1'b0;
        o_ready = 1'b1;
        wr_row  = '0;
        @(posedge clk);
        #1;

        // Reset then idle
        cycle();
        cycle();
        check("rst_occ", occ, 0);
        check("rst_valid", o_valid, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_ovf", ovf, 0);
        check("rst_last", o_last, 0);
        check("rst_data", o_data, 0);
        reset = 1'b0;
        rd0 = rd_cnt;
        v0  = vld_cnt;
        repeat (50) cycle();
        check("idle_rd", rd_cnt - rd0, 0);
        check("idle_valid", vld_cnt - v0, 0);
        check("idle_occ", occ, 0);

        // Single row, o_ready held high
        rd0 = rd_cnt; h0 = hs_cnt; l0 = last_cnt; v0 = vld_cnt;
        wr_pulse(0);
        check("row_occ_up", occ, 1);
        wait_hs("row_hs", h0 + 16, 60);
        repeat (3) cycle();
        check("row_rd_pulses", rd_cnt - rd0, 1);
        check("row_lasts", last_cnt - l0, 1);
        check("row_valid_cycles", vld_cnt - v0, 16);
        check("row_occ_end", occ, 0);
        check("row_sb_drained", exp_q.size(), 0);

        // Backpressure: o_ready 1,0,0 repeating
        h0 = hs_cnt; l0 = last_cnt;
        wr_pulse(0);
        for (int i = 0; i < 150 && (hs_cnt - h0) < 16; i++) begin
            o_ready = (i % 3 == 0);
            cycle();
        end
        o_ready = 1'b1;
        repeat (3) cycle();
        check("bp_hs", hs_cnt - h0, 16);
        check("bp_lasts", last_cnt - l0, 1);
        check("bp_sb_drained", exp_q.size(), 0);

        // Back-to-back rows
        h0 = hs_cnt; l0 = last_cnt;
        rd_cycs.delete();
        last_cycs.delete();
        wr_pulse(0);
        wr_pulse(16);
        wr_pulse(32);
        wait_hs("b2b_hs", h0 + 48, 200);
        repeat (3) cycle();
        check("b2b_lasts", last_cnt - l0, 3);
        check("b2b_rd_count", rd_cycs.size(), 3);
        if (rd_cycs.size() >= 3 && last_cycs.size() >= 2) begin
            check("b2b_rd2_gap", rd_cycs[1], last_cycs[0] + 1);
            check("b2b_rd3_gap", rd_cycs[2], last_cycs[1] + 1);
        end
        check("b2b_occ_end", occ, 0);
        check("b2b_sb_drained", exp_q.size(), 0);

        // Coincident write/read, then overflow with o_ready low
        o_ready = 1'b0;
        wr_pulse(100);
        check("sim_occ_pre", occ, 1);
        cycle();
        check("sim_rd_high", fifo_rd, 1);
        wr_pulse(200);
        check("sim_occ_same", occ, 1);
        for (int i = 0; i < 15; i++) wr_pulse(300 + 16 * i);
        check("ovf_full_occ", occ, 16);
        check("ovf_not_yet", ovf, 0);
        wr_pulse(600);
        wr_pulse(700);
        check("ovf_sat_occ", occ, 16);
        check("ovf_set", ovf, 1);
        repeat (5) cycle();
        check("ovf_sticky", ovf, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete();
        check("ovf_cleared", ovf, 0);
        check("ovf_rst_occ", occ, 0);
        check("ovf_rst_valid", o_valid, 0);

        // Reset at word 7 of a row
        o_ready = 1'b1;
        h0 = hs_cnt;
        wr_pulse(400);
        for (int i = 0; i < 40 && (hs_cnt - h0) < 6; i++) cycle();
        check("mid_word7_valid", o_valid, 1);
        check("mid_word7_data", o_data, 407);
        o_ready = 1'b0;
        reset   = 1'b1;
        cycle();
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_occ", occ, 0);
        check("mid_rst_last", o_last, 0);
        check("mid_rst_data", o_data, 0);
        exp_q.delete();
        reset   = 1'b0;
        o_ready = 1'b1;
        rd0 = rd_cnt; v0 = vld_cnt;
        repeat (10) cycle();
        check("mid_idle_rd", rd_cnt - rd0, 0);
        check("mid_idle_valid", vld_cnt - v0, 0);
        h0 = hs_cnt; l0 = last_cnt;
        wr_pulse(500);
        wait_hs("mid_clean_hs", h0 + 16, 60);
        repeat (3) cycle();
        check("mid_clean_lasts", last_cnt - l0, 1);
        check("mid_sb_drained", exp_q.size(), 0);
        check("mid_occ_end", occ, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
